// File: rtl/refresh_cmd_arbiter.sv
// rtl/refresh_cmd_arbiter.sv - refresh vs bank-machine command arbiter
// Blocks the bank machines on a refresh request, drains to all-idle, then forwards refresher commands.
module refresh_cmd_arbiter #(
  parameter int NBANKS  = 8,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ref_cmd_valid,
  output logic              ref_cmd_ready,
  input  logic              ref_cmd_last,
  input  logic [16:0]       ref_cmd_a,
  input  logic [2:0]        ref_cmd_ba,
  input  logic              ref_cmd_cas,
  input  logic              ref_cmd_ras,
  input  logic              ref_cmd_we,
  input  logic              norm_cmd_valid,
  output logic              norm_cmd_ready,
  input  logic [16:0]       norm_cmd_a,
  input  logic [2:0]        norm_cmd_ba,
  input  logic              norm_cmd_cas,
  input  logic              norm_cmd_ras,
  input  logic              norm_cmd_we,
  input  logic [NBANKS-1:0] bank_idle,
  output logic              bank_block,
  output logic              out_cmd_valid,
  input  logic              out_cmd_ready,
  output logic [16:0]       out_cmd_a,
  output logic [2:0]        out_cmd_ba,
  output logic              out_cmd_cas,
  output logic              out_cmd_ras,
  output logic              out_cmd_we,
  output logic              refresh_active,
  output logic [CNT_W-1:0]  refresh_count,
  output logic              timeout_err,
  output logic              drop_err
);

  localparam int DW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] TIMEOUT_V = DW'(TIMEOUT);

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_REFRESH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             drop_err_q, drop_err_d;

  logic all_idle;
  logic ref_is_cmd;

  assign all_idle   = &bank_idle;
  assign ref_is_cmd = ref_cmd_cas | ref_cmd_ras | ref_cmd_we;

  // Outputs are purely combinational so the command path adds no latency;
  // everything is held at zero while reset is asserted.
  always_comb begin
    ref_cmd_ready  = 1'b0;
    norm_cmd_ready = 1'b0;
    bank_block     = 1'b0;
    out_cmd_valid  = 1'b0;
    out_cmd_a      = '0;
    out_cmd_ba     = '0;
    out_cmd_cas    = 1'b0;
    out_cmd_ras    = 1'b0;
    out_cmd_we     = 1'b0;
    refresh_active = 1'b0;
    refresh_count  = '0;
    timeout_err    = 1'b0;
    drop_err       = 1'b0;
    if (sys_rst_n) begin
      refresh_count = ref_cnt_q;
      timeout_err   = timeout_err_q;
      drop_err      = drop_err_q;
      case (state_q)
        ST_NORMAL: begin
          out_cmd_valid  = norm_cmd_valid;
          out_cmd_a      = norm_cmd_a;
          out_cmd_ba     = norm_cmd_ba;
          out_cmd_cas    = norm_cmd_cas;
          out_cmd_ras    = norm_cmd_ras;
          out_cmd_we     = norm_cmd_we;
          norm_cmd_ready = out_cmd_ready;
        end
        ST_DRAIN: begin
          bank_block = 1'b1;
        end
        ST_REFRESH: begin
          bank_block     = 1'b1;
          ref_cmd_ready  = 1'b1;
          refresh_active = 1'b1;
          out_cmd_valid  = ref_cmd_valid & ref_is_cmd;
          out_cmd_a      = ref_cmd_a;
          out_cmd_ba     = ref_cmd_ba;
          out_cmd_cas    = ref_cmd_cas;
          out_cmd_ras    = ref_cmd_ras;
          out_cmd_we     = ref_cmd_we;
        end
        default: begin
          bank_block = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    ref_cnt_d     = ref_cnt_q;
    timeout_err_d = timeout_err_q;
    drop_err_d    = drop_err_q;
    case (state_q)
      ST_NORMAL: begin
        if (ref_cmd_valid) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (!ref_cmd_valid) begin
          state_d     = ST_NORMAL;
          drain_cnt_d = '0;
        end else if (all_idle) begin
          state_d     = ST_REFRESH;
          drain_cnt_d = '0;
        end else begin
          // Saturate rather than wrap so the flag cannot be missed on a long stall.
          drain_cnt_d = (drain_cnt_q == TIMEOUT_V) ? drain_cnt_q : drain_cnt_q + DW'(1);
          if (drain_cnt_d == TIMEOUT_V) begin
            timeout_err_d = 1'b1;
          end
        end
      end
      ST_REFRESH: begin
        // The refresher has no stall path, so a refused command is simply lost.
        if (out_cmd_valid && !out_cmd_ready) begin
          drop_err_d = 1'b1;
        end
        if (ref_cmd_last) begin
          ref_cnt_d = ref_cnt_q + CNT_W'(1);
          state_d   = ST_NORMAL;
        end
      end
      default: begin
        state_d     = ST_NORMAL;
        drain_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= ST_NORMAL;
      drain_cnt_q   <= '0;
      ref_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      timeout_err_q <= timeout_err_d;
      drop_err_q    <= drop_err_d;
    end
  end

endmodule
